// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss.cc BCD stopwatch.
package stopwatch_pkg;

    localparam int unsigned CS_MAX  = 99;
    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned DIGIT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } sw_state_e;

    typedef struct packed {
        logic [DIGIT_W-1:0] min;
        logic [DIGIT_W-1:0] sec;
        logic [DIGIT_W-1:0] cs;
    } sw_time_t;

    // Two-digit BCD encoding of a 0..99 value.
    function automatic logic [DIGIT_W-1:0] to_bcd8(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter with enable, sync clear, programmable BCD maximum and carry-out.
module bcd_mod_counter
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [DIGIT_W-1:0] max,
    output logic [DIGIT_W-1:0] nxt_c,
    output logic               carry_c
);

    logic [DIGIT_W-1:0] q;

    // Next value is exported so the owner can register it alongside q.
    always_comb begin
        nxt_c   = q;
        carry_c = 1'b0;
        if (clr) begin
            nxt_c = '0;
        end else if (en) begin
            if (q == max) begin
                nxt_c   = '0;
                carry_c = 1'b1;
            end else if (q[3:0] == 4'd9) begin
                nxt_c = {q[7:4] + 4'd1, 4'd0};
            end else begin
                nxt_c = {q[7:4], q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= nxt_c;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Up-counting BCD stopwatch mm:ss.cc with start/stop, clear and wrap strobe.
// Define STOPWATCH_LAP_EN to enable the lap hold register and display freeze.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX_MIN = 59
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               start_stop,
    input  logic               clear,
    input  logic               lap,
    output logic               running,
    output logic               frozen,
    output logic [DIGIT_W-1:0] disp_min,
    output logic [DIGIT_W-1:0] disp_sec,
    output logic [DIGIT_W-1:0] disp_cs,
    output logic               wrap
);

    sw_state_e state;
    sw_time_t  live_nxt_c;
    sw_time_t  show_c;
    logic      cnt_en_c;
    logic      cs_carry_c;
    logic      sec_carry_c;
    logic      min_carry_c;

    // A start_stop or clear on the same cycle swallows the tick.
    assign cnt_en_c = (state == RUN) && tick && !clear && !start_stop;

    bcd_mod_counter u_cs (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clear),
        .en      (cnt_en_c),
        .max     (to_bcd8(CS_MAX)),
        .nxt_c   (live_nxt_c.cs),
        .carry_c (cs_carry_c)
    );

    bcd_mod_counter u_sec (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clear),
        .en      (cs_carry_c),
        .max     (to_bcd8(SEC_MAX)),
        .nxt_c   (live_nxt_c.sec),
        .carry_c (sec_carry_c)
    );

    bcd_mod_counter u_min (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clear),
        .en      (sec_carry_c),
        .max     (to_bcd8(MAX_MIN)),
        .nxt_c   (live_nxt_c.min),
        .carry_c (min_carry_c)
    );

`ifdef STOPWATCH_LAP_EN
    sw_time_t hold;
    sw_time_t hold_nxt_c;
    logic     frz_nxt_c;

    // While unfrozen the display equals the live count, so it is the capture source.
    always_comb begin
        frz_nxt_c  = frozen;
        hold_nxt_c = hold;
        if (clear) begin
            frz_nxt_c = 1'b0;
        end else if (lap && (state != IDLE)) begin
            if (frozen) begin
                frz_nxt_c = 1'b0;
            end else begin
                frz_nxt_c  = 1'b1;
                hold_nxt_c = {disp_min, disp_sec, disp_cs};
            end
        end
        show_c = frz_nxt_c ? hold_nxt_c : live_nxt_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frozen <= 1'b0;
            hold   <= '0;
        end else begin
            frozen <= frz_nxt_c;
            hold   <= hold_nxt_c;
        end
    end
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign frozen     = 1'b0;
    assign show_c     = live_nxt_c;
`endif

    // Run/stop FSM with registered display and wrap strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            running  <= 1'b0;
            wrap     <= 1'b0;
            disp_min <= '0;
            disp_sec <= '0;
            disp_cs  <= '0;
        end else begin
            wrap     <= min_carry_c;
            disp_min <= show_c.min;
            disp_sec <= show_c.sec;
            disp_cs  <= show_c.cs;
            if (clear) begin
                state   <= IDLE;
                running <= 1'b0;
            end else if (start_stop) begin
                case (state)
                    IDLE, STOP: begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    RUN: begin
                        state   <= STOP;
                        running <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core; a second instance with MAX_MIN=2 exercises wrap.
module tb_stopwatch_core;
    import stopwatch_pkg::*;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick, start_stop, clear, lap;
    logic       running0, frozen0, wrap0, running1, frozen1, wrap1;
    logic [7:0] min0, sec0, cs0, min1, sec1, cs1;

    int checks   = 0;
    int failures = 0;
    int wraps0   = 0;
    int wraps1   = 0;

    logic [27:0] exp_q[$];
    string       name_q[$];
    logic [27:0] e;
    logic [26:0] act;
    string       nm;

    always #5 clk = ~clk;

    stopwatch_core dut0 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
        .running(running0), .frozen(frozen0), .disp_min(min0), .disp_sec(sec0), .disp_cs(cs0),
        .wrap(wrap0)
    );

    stopwatch_core #(.MAX_MIN(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
        .running(running1), .frozen(frozen1), .disp_min(min1), .disp_sec(sec1), .disp_cs(cs1),
        .wrap(wrap1)
    );

    // Monitor: pops every pending expectation and compares on the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = e[27] ? {running1, frozen1, wrap1, min1, sec1, cs1}
                        : {running0, frozen0, wrap0, min0, sec0, cs0};
            checks++;
            if (act !== e[26:0]) begin
                failures++;
                $display("FAIL %s: got run/frz/wrap/mm:ss.cc=%h required %h", nm, act, e[26:0]);
            end
        end
        if (wrap0 === 1'b1) wraps0++;
        if (wrap1 === 1'b1) wraps1++;
    end

    task automatic expect_out(input bit sel, input logic r, input logic f, input logic w,
                              input logic [7:0] m, input logic [7:0] s, input logic [7:0] c,
                              input string n);
        exp_q.push_back({sel, r, f, w, m, s, c});
        name_q.push_back(n);
    endtask

    task automatic step(input logic ss, input logic clr, input logic tk, input logic lp);
        start_stop = ss;
        clear      = clr;
        tick       = tk;
        lap        = lp;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        clear      = 1'b0;
        tick       = 1'b0;
        lap        = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_count(input int act_v, input int req, input string n);
        checks++;
        if (act_v != req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", n, act_v, req);
        end
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_out(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, "reset0");
        expect_out(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, "reset1");
        rst_n = 1'b1;

        step(1, 0, 0, 0);
        expect_out(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, "start");
        ticks(100);
        expect_out(0, 1, 0, 0, 8'h00, 8'h01, 8'h00, "100_ticks");
        check_count(wraps0, 0, "no_wrap_100");

        step(0, 1, 0, 0);
        expect_out(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, "clear_idle");
        step(1, 0, 0, 0);
        ticks(42);
        expect_out(0, 1, 0, 0, 8'h00, 8'h00, 8'h42, "at_042");
        step(1, 0, 1, 0);
        expect_out(0, 0, 0, 0, 8'h00, 8'h00, 8'h42, "stop_tick_dropped");
        step(0, 0, 1, 0);
        expect_out(0, 0, 0, 0, 8'h00, 8'h00, 8'h42, "stop_holds");
        step(1, 0, 1, 0);
        expect_out(0, 1, 0, 0, 8'h00, 8'h00, 8'h42, "resume_tick_dropped");
        ticks(3);
        expect_out(0, 1, 0, 0, 8'h00, 8'h00, 8'h45, "resume_045");

        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        ticks(1234);
        expect_out(0, 1, 0, 0, 8'h00, 8'h12, 8'h34, "at_1234");
        step(0, 0, 0, 1);
        expect_out(0, 1, LAP, 0, 8'h00, 8'h12, 8'h34, "lap_capture");
        ticks(50);
        if (LAP) expect_out(0, 1, 1, 0, 8'h00, 8'h12, 8'h34, "lap_held");
        else     expect_out(0, 1, 0, 0, 8'h00, 8'h12, 8'h84, "lap_held");
        step(0, 0, 0, 1);
        expect_out(0, 1, 0, 0, 8'h00, 8'h12, 8'h84, "lap_release");

        step(0, 0, 0, 1);
        step(0, 1, 1, 0);
        expect_out(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, "clear_with_tick");
        step(0, 0, 0, 1);
        expect_out(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, "lap_in_idle");
        step(1, 1, 0, 0);
        expect_out(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, "clear_beats_start");

        step(1, 0, 0, 0);
        ticks(17999);
        expect_out(1, 1, 0, 0, 8'h02, 8'h59, 8'h99, "max_count");
        step(0, 0, 1, 0);
        expect_out(1, 1, 0, 1, 8'h00, 8'h00, 8'h00, "wrap_zero");
        expect_out(0, 1, 0, 0, 8'h03, 8'h00, 8'h00, "no_wrap_at_59max");
        step(0, 0, 0, 0);
        expect_out(1, 1, 0, 0, 8'h00, 8'h00, 8'h00, "wrap_one_cycle");
        step(0, 0, 1, 0);
        expect_out(1, 1, 0, 0, 8'h00, 8'h00, 8'h01, "after_wrap");
        check_count(wraps1, 1, "wrap_pulses");

        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        ticks(18755);
        expect_out(0, 1, 0, 0, 8'h03, 8'h07, 8'h55, "at_030755");
        rst_n = 1'b0;
        step(0, 0, 1, 0);
        rst_n = 1'b1;
        expect_out(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, "mid_reset0");
        expect_out(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, "mid_reset1");
        step(0, 0, 1, 0);
        expect_out(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, "tick_ignored_idle");
        step(1, 0, 0, 0);
        expect_out(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, "restart");
        step(0, 0, 1, 0);
        expect_out(0, 1, 0, 0, 8'h00, 8'h00, 8'h01, "restart_tick");

        @(negedge clk);
        #1;
        check_count(exp_q.size(), 0, "scoreboard_drained");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Up-counting BCD stopwatch for the digital clock: counts mm:ss.cc upward on a 1/100 s enable strobe from the prescaler. It has start/stop, clear and optional lap-freeze controls. It is the counting-up counterpart of the loadable down-counter and threshold path used by the countdown timer, and feeds the display multiplexer with three BCD digit pairs plus a wrap strobe.

## Interface
- `MAX_MIN`, default 59: highest minute value before wrap; 1..99, BCD-representable.
- `clk`  in  1  system clock, all logic rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tick`  in  1  1/100 s count enable, one `clk` wide per period.
- `start_stop`  in  1  single-cycle pulse; toggles run/stop.
- `clear`  in  1  single-cycle pulse; zeroes count, returns to IDLE.
- `lap`  in  1  single-cycle pulse; toggles display freeze (only with `STOPWATCH_LAP_EN`).
- `running`  out  1  high in RUN.
- `frozen`  out  1  high while display shows a held lap value.
- `disp_min`  out  8  BCD minutes shown.
- `disp_sec`  out  8  BCD seconds shown.
- `disp_cs`  out  8  BCD centiseconds shown.
- `wrap`  out  1  one-cycle pulse when count rolls from MAX_MIN:59.99 to 00:00.00.

## Operation
- FSM states: IDLE (count zero, stopped), RUN, STOP (count non-zero, held).
- IDLE --start_stop--> RUN; RUN --start_stop--> STOP; STOP --start_stop--> RUN. Any state --clear--> IDLE.
- Count advances only in RUN with `tick`=1: cs 00..99, carry to sec 00..59, carry to min 00..MAX_MIN, then wrap to all zero.
- Each BCD nibble stays in 0..9 at all times. Tens-of-seconds stays in 0..5.
- Priority on the same cycle: `rst_n` low > `clear` > `start_stop` > `tick`.
- `tick` on the same cycle as `start_stop` in RUN→STOP: the tick is discarded.
- `tick` on the same cycle as `start_stop` in STOP/IDLE→RUN: the tick is discarded. Counting begins with the next tick.
- `wrap` asserts on the cycle the rolled-over zero count is registered. The FSM stays in RUN.
- Lap: `lap` while not frozen captures the live count into the hold register and sets `frozen`. `lap` while frozen clears `frozen`. The live count keeps counting throughout.
- `lap` is accepted in RUN and STOP and ignored in IDLE. `clear` also clears `frozen`.
- Display outputs show the hold register when `frozen`=1, otherwise the live count.

## Timing
- Reset values: `running`=0, `frozen`=0, `disp_*`=8'h00, `wrap`=0, FSM=IDLE.
- Reset takes effect on the first rising edge with `rst_n` low. A reset mid-count discards the count and lap.
- All outputs are registered.
- A tick sampled at edge N is visible on `disp_*` after edge N; latency is 1 clk.
- A control pulse sampled at edge N updates `running`/`frozen` after edge N.
- Back-to-back ticks on consecutive cycles are legal and each is counted; bench acceleration relies on this.

## Configuration
- `STOPWATCH_LAP_EN` defined: the hold register, the `frozen` logic and the lap input are active.
- `STOPWATCH_LAP_EN` undefined: `lap` is ignored, `frozen` is tied 0, the display always shows the live count, and no hold register is synthesised.

## Structure
- Package `stopwatch_pkg` holds:
  - the FSM state enum (IDLE, RUN, STOP);
  - BCD limit constants (CS_MAX=99, SEC_MAX=59);
  - the packed time type {min, sec, cs} used by the live and hold registers.
- Sub-module `bcd_mod_counter`: a two-digit BCD counter with enable, sync clear, programmable maximum and carry-out. It is instantiated three times, for cs, sec and min.

## Test plan
- Reset then start_stop, 100 ticks → `disp` = 00:01.00, `running`=1, `wrap` never asserts.
- Drive the count to MAX_MIN=59 at 59:59.99, then 1 tick → `disp` = 00:00.00, `wrap` high exactly one cycle, `running` stays 1.
- In RUN at 00:00.42, start_stop and tick in the same cycle → STOP, `disp` stays 00:00.42. A later start_stop and 3 ticks → 00:00.45.
- At 00:12.34, assert lap, then 50 ticks → `disp` holds 00:12.34 with `frozen`=1. A second lap → `disp` = 00:12.84, `frozen`=0. With the macro undefined, `disp` = 00:12.84 throughout.
- Mid-RUN, clear and tick in the same cycle → `disp` = 00:00.00, IDLE, `running`=0, `frozen`=0.
- Pull `rst_n` low for one cycle during RUN at 03:07.55 → all outputs return to reset values on that edge, and ticks are ignored until the next start_stop.
